// File: rtl/regfile_wb_if.sv
// Writeback request/response bundle between the two requesters, the arbiter
// and the register-file write port.
interface regfile_wb_if #(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NUM_REGS = 16
);
  logic                a_valid;
  logic                a_ready;
  logic [AW-1:0]       a_addr;
  logic [DW-1:0]       a_data;
  logic                b_valid;
  logic                b_ready;
  logic [AW-1:0]       b_addr;
  logic [DW-1:0]       b_data;
  logic                reg_wr;
  logic [AW-1:0]       wr_addr;
  logic [DW-1:0]       wr_din;
  logic [NUM_REGS-1:0] pending;
  logic                drop_err;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, reg_wr, wr_addr, wr_din, pending, drop_err
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, reg_wr, wr_addr, wr_din, pending, drop_err
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-port writeback arbiter with per-port FIFOs and a registered write stage.
// Define WB_RR_EN for round-robin arbitration; default is fixed A-over-B priority.
module regfile_wb_arbiter #(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst,
  regfile_wb_if.slave  wb
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        mem [2][DEPTH];
  logic [PW-1:0] wp  [2];
  logic [PW-1:0] rp  [2];
  logic [CW-1:0] cnt [2];

  entry_t        in_e   [2];
  logic          push   [2];
  logic          pop    [2];
  logic          full   [2];
  logic          nempty [2];
  logic          issue;
  logic          gnt_b;
  entry_t        head;

  logic          reg_wr;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_din;
  logic          drop_err;
  logic [NUM_REGS-1:0] pending;

`ifdef WB_RR_EN
  logic          last_grant;   // 0 = A, 1 = B
`endif

  function automatic logic [NUM_REGS-1:0] onehot(input logic [AW-1:0] addr);
    logic [NUM_REGS-1:0] oh;
    oh = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if ((int'(addr) % int'(NUM_REGS)) == r) oh[r] = 1'b1;
    end
    return oh;
  endfunction

  function automatic logic in_range(input logic [AW-1:0] addr);
    return int'(addr) < int'(NUM_REGS);
  endfunction

  // FIFO status, handshake and grant selection
  always_comb begin
    in_e[0] = '{addr: wb.a_addr, data: wb.a_data};
    in_e[1] = '{addr: wb.b_addr, data: wb.b_data};
    for (int p = 0; p < 2; p++) begin
      full[p]   = (cnt[p] == CW'(DEPTH));
      nempty[p] = (cnt[p] != '0);
    end
    wb.a_ready = !rst && !full[0];
    wb.b_ready = !rst && !full[1];
    push[0]    = wb.a_valid && wb.a_ready;
    push[1]    = wb.b_valid && wb.b_ready;
`ifdef WB_RR_EN
    gnt_b = nempty[1] && (!nempty[0] || !last_grant);
`else
    gnt_b = nempty[1] && !nempty[0];
`endif
    issue  = nempty[0] || nempty[1];
    pop[0] = issue && !gnt_b;
    pop[1] = gnt_b;
    head   = gnt_b ? mem[1][rp[1]] : mem[0][rp[0]];
  end

  // Entry i of a FIFO is live when its distance from the read pointer is below the count
  always_comb begin
    pending = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(PW'(PW'(i) - rp[p])) < cnt[p]) pending = pending | onehot(mem[p][i].addr);
      end
    end
    if (reg_wr) pending = pending | onehot(wr_addr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        wp[p]  <= '0;
        rp[p]  <= '0;
        cnt[p] <= '0;
      end
      reg_wr   <= 1'b0;
      wr_addr  <= '0;
      wr_din   <= '0;
      drop_err <= 1'b0;
`ifdef WB_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (push[p]) begin
          mem[p][wp[p]] <= in_e[p];
          wp[p]         <= wp[p] + PW'(1);
        end
        if (pop[p]) rp[p] <= rp[p] + PW'(1);
        cnt[p] <= cnt[p] + CW'(push[p]) - CW'(pop[p]);
      end
      reg_wr   <= 1'b0;
      drop_err <= 1'b0;
      if (issue) begin
        // Out-of-range heads are consumed but never reach the register file
        if (in_range(head.addr)) begin
          reg_wr  <= 1'b1;
          wr_addr <= head.addr;
          wr_din  <= head.data;
        end else begin
          drop_err <= 1'b1;
        end
`ifdef WB_RR_EN
        last_grant <= gnt_b;
`endif
      end
    end
  end

  assign wb.reg_wr   = reg_wr;
  assign wb.wr_addr  = wr_addr;
  assign wb.wr_din   = wr_din;
  assign wb.drop_err = drop_err;
  assign wb.pending  = pending;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed vector bench for regfile_wb_arbiter (default fixed-priority build).
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst;

  regfile_wb_if #(.DW(32), .AW(5), .NUM_REGS(16)) wb ();

  regfile_wb_arbiter #(.DW(32), .AW(5), .NUM_REGS(16), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic        ar;
    logic        br;
    logic        rw;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [15:0] pend;
    logic        de;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input int av, aa, ad, bv, ba, bd, ar, br, rw, wa, wd, pend, de);
    vec_t v;
    v.av = 1'(av);  v.aa = 5'(aa);  v.ad = 32'(ad);
    v.bv = 1'(bv);  v.ba = 5'(ba);  v.bd = 32'(bd);
    v.ar = 1'(ar);  v.br = 1'(br);  v.rw = 1'(rw);
    v.wa = 5'(wa);  v.wd = 32'(wd); v.pend = 16'(pend); v.de = 1'(de);
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    wb.a_valid = av; wb.a_addr = aa; wb.a_data = ad;
    wb.b_valid = bv; wb.b_addr = ba; wb.b_data = bd;
  endtask

  initial begin
    // Each row: inputs held for one cycle; expected outputs seen before that cycle's edge
    //   av aa ad       bv ba bd      ar br rw wa wd       pend   de
    add(0, 0, 0,       0, 0, 0,      1, 1, 0, 0, 0,       'h0,   0);
    add(1, 3, 'hDEAD,  0, 0, 0,      1, 1, 0, 0, 0,       'h0,   0);
    add(0, 0, 0,       0, 0, 0,      1, 1, 0, 0, 0,       'h8,   0);
    add(0, 0, 0,       0, 0, 0,      1, 1, 1, 3, 'hDEAD,  'h8,   0);
    add(0, 0, 0,       0, 0, 0,      1, 1, 0, 0, 0,       'h0,   0);
    add(1, 5, 'h11,    0, 0, 0,      1, 1, 0, 0, 0,       'h0,   0);
    add(1, 5, 'h22,    0, 0, 0,      1, 1, 0, 0, 0,       'h20,  0);
    add(0, 0, 0,       0, 0, 0,      1, 1, 1, 5, 'h11,    'h20,  0);
    add(0, 0, 0,       0, 0, 0,      1, 1, 1, 5, 'h22,    'h20,  0);
    add(0, 0, 0,       0, 0, 0,      1, 1, 0, 0, 0,       'h0,   0);
    add(0, 0, 0,       1, 20, 7,     1, 1, 0, 0, 0,       'h0,   0);
    add(1, 2, 'hAB,    0, 0, 0,      1, 1, 0, 0, 0,       'h10,  0);
    add(0, 0, 0,       0, 0, 0,      1, 1, 0, 0, 0,       'h4,   1);
    add(0, 0, 0,       0, 0, 0,      1, 1, 1, 2, 'hAB,    'h4,   0);
    add(0, 0, 0,       0, 0, 0,      1, 1, 0, 0, 0,       'h0,   0);
    add(1, 1, 'hA0,    1, 6, 'hB0,   1, 1, 0, 0, 0,       'h0,   0);
    add(1, 1, 'hA1,    1, 6, 'hB1,   1, 1, 0, 0, 0,       'h42,  0);
    add(1, 1, 'hA2,    1, 6, 'hB2,   1, 0, 1, 1, 'hA0,    'h42,  0);
    add(1, 1, 'hA3,    1, 6, 'hB2,   1, 0, 1, 1, 'hA1,    'h42,  0);
    add(0, 0, 0,       1, 6, 'hB2,   1, 0, 1, 1, 'hA2,    'h42,  0);
    add(0, 0, 0,       1, 6, 'hB2,   1, 0, 1, 1, 'hA3,    'h42,  0);
    add(0, 0, 0,       1, 6, 'hB2,   1, 1, 1, 6, 'hB0,    'h40,  0);
    add(0, 0, 0,       0, 0, 0,      1, 1, 1, 6, 'hB1,    'h40,  0);
    add(0, 0, 0,       0, 0, 0,      1, 1, 1, 6, 'hB2,    'h40,  0);
    add(0, 0, 0,       0, 0, 0,      1, 1, 0, 0, 0,       'h0,   0);

    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst a_ready", 32'(wb.a_ready), 32'd0);
    check("rst b_ready", 32'(wb.b_ready), 32'd0);
    check("rst reg_wr",  32'(wb.reg_wr),  32'd0);
    check("rst wr_addr", 32'(wb.wr_addr), 32'd0);
    check("rst wr_din",  wb.wr_din,       32'd0);
    check("rst pending", 32'(wb.pending), 32'd0);
    check("rst drop",    32'(wb.drop_err), 32'd0);
    rst = 1'b0;

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].av, vq[i].aa, vq[i].ad, vq[i].bv, vq[i].ba, vq[i].bd);
      #1;
      check($sformatf("row%0d a_ready", i), 32'(wb.a_ready),  32'(vq[i].ar));
      check($sformatf("row%0d b_ready", i), 32'(wb.b_ready),  32'(vq[i].br));
      check($sformatf("row%0d reg_wr", i),  32'(wb.reg_wr),   32'(vq[i].rw));
      check($sformatf("row%0d pending", i), 32'(wb.pending),  32'(vq[i].pend));
      check($sformatf("row%0d drop", i),    32'(wb.drop_err), 32'(vq[i].de));
      if (vq[i].rw) begin
        check($sformatf("row%0d wr_addr", i), 32'(wb.wr_addr), 32'(vq[i].wa));
        check($sformatf("row%0d wr_din", i),  wb.wr_din,       vq[i].wd);
      end
    end

    // Mid-operation reset with three entries in flight
    @(negedge clk);
    drive(1'b1, 5'd1, 32'h51, 1'b1, 5'd7, 32'h52);
    @(negedge clk);
    drive(1'b1, 5'd4, 32'h53, 1'b0, '0, '0);
    #1;
    check("flush pre pending", 32'(wb.pending), 32'h82);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    rst = 1'b1;
    #1;
    check("flush queued pending", 32'(wb.pending), 32'h92);
    check("flush rst a_ready",    32'(wb.a_ready), 32'd0);
    check("flush rst b_ready",    32'(wb.b_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("flush reg_wr",  32'(wb.reg_wr),  32'd0);
    check("flush pending", 32'(wb.pending), 32'd0);
    check("flush a_ready", 32'(wb.a_ready), 32'd1);
    check("flush b_ready", 32'(wb.b_ready), 32'd1);
    check("flush drop",    32'(wb.drop_err), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("post flush%0d reg_wr", k), 32'(wb.reg_wr), 32'd0);
      check($sformatf("post flush%0d wr_din", k), wb.wr_din,      32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
